// File: rtl/uart_rx.sv
// Serial UART receiver: 2-flop line synchroniser, mid-bit sampling on a 16x tick, LSB-first data, stop-bit check.
// Latency: o_data/o_valid/o_frame_error are registered one cycle after the stop-bit sample edge.
// Backpressure: none; o_valid is a single-cycle pulse and a downstream consumer must capture it.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_error
);

    localparam int TICK_SPAN = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TW        = $clog2(TICK_SPAN);
    localparam int BW        = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] MID_TICK  = TW'(7);
    localparam logic [TW-1:0] LAST_TICK = TW'(15);
    localparam logic [TW-1:0] STOP_TICK = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;

    // The line is idle high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[NB_DATA-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == STOP_TICK) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                o_data  <= shreg;
                                o_valid <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                o_frame_error <= 1'b1;
                                state         <= WAIT_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A break or stuck-low line must return high before a new start bit is honoured.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed table-driven bench for uart_rx: 4 clocks per tick, 64 clocks per bit.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx_data;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_error;

    logic [1:0] tick_div = 2'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    int vcnt = 0, fcnt = 0, both_cnt = 0, wide_cnt = 0, cyc = 0;
    logic pv = 1'b0, pf = 1'b0;
    int valid_cyc_q[$];

    uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx_data    (i_rx_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_error(o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) tick_div <= tick_div + 2'd1;
    assign i_tick = (tick_div == 2'd3);

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        cyc++;
        if (i_reset) begin
            if (o_valid) begin
                vcnt++;
                valid_cyc_q.push_back(cyc);
            end
            if (o_frame_error) fcnt++;
            if (o_valid && o_frame_error) both_cnt++;
            if ((o_valid && pv) || (o_frame_error && pf)) wide_cnt++;
        end
        pv = o_valid;
        pf = o_frame_error;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         idle_bits;
        logic       glitch_first;
        logic [7:0] exp_data;
        int         exp_v;
        int         exp_f;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic line_bits(input logic b, input int nbits);
        i_rx_data = b;
        repeat (nbits * BIT_CLK) @(negedge i_clk);
    endtask

    // Acts as the transmitter driving the serial line (loopback source).
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int idle_bits);
        line_bits(1'b0, 1);
        for (int k = 0; k < 8; k++) line_bits(d[k], 1);
        if (stop_ok) begin
            line_bits(1'b1, 1);
        end else begin
            line_bits(1'b0, 4);
        end
        if (idle_bits > 0) line_bits(1'b1, idle_bits);
    endtask

    initial begin
        int v0, f0;
        tbl[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF, 1, 0};
        tbl[3] = '{8'h3C, 1'b1, 2, 1'b1, 8'h3C, 1, 0};
        tbl[4] = '{8'h55, 1'b1, 2, 1'b0, 8'h55, 1, 0};
        tbl[5] = '{8'h3C, 1'b0, 2, 1'b0, 8'h55, 0, 1};
        tbl[6] = '{8'h81, 1'b1, 2, 1'b0, 8'h81, 1, 0};
        tbl[7] = '{8'h4F, 1'b1, 0, 1'b0, 8'h4F, 1, 0};
        tbl[8] = '{8'hB2, 1'b1, 2, 1'b0, 8'hB2, 1, 0};

        i_reset   = 1'b0;
        i_rx_data = 1'b1;
        repeat (5) @(negedge i_clk);
        chk("reset_data", 32'(o_data), 32'h0);
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_ferr", 32'(o_frame_error), 32'h0);
        i_reset = 1'b1;
        line_bits(1'b1, 3);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].glitch_first) begin
                v0 = vcnt;
                f0 = fcnt;
                i_rx_data = 1'b0;
                repeat (16) @(negedge i_clk);
                line_bits(1'b1, 2);
                chk("glitch_valid", 32'(vcnt - v0), 32'h0);
                chk("glitch_ferr", 32'(fcnt - f0), 32'h0);
            end
            v0 = vcnt;
            f0 = fcnt;
            send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].idle_bits);
            chk($sformatf("vec%0d_valid", i), 32'(vcnt - v0), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_ferr", i), 32'(fcnt - f0), 32'(tbl[i].exp_f));
            chk($sformatf("vec%0d_data", i), 32'(o_data), 32'(tbl[i].exp_data));
        end

        // Back-to-back 0x00 / 0xFF are valid pulses #1 and #2: exactly 10 bits apart.
        chk("b2b_spacing", 32'(valid_cyc_q[2] - valid_cyc_q[1]), 32'(10 * BIT_CLK));

        // Reset after data bit 3 of 0xF0, frame remainder sent while held in reset.
        v0 = vcnt;
        f0 = fcnt;
        line_bits(1'b0, 1);
        line_bits(1'b0, 4);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("midrst_data", 32'(o_data), 32'h0);
        chk("midrst_valid", 32'(o_valid), 32'h0);
        chk("midrst_ferr", 32'(o_frame_error), 32'h0);
        line_bits(1'b1, 5);
        line_bits(1'b1, 2);
        i_reset = 1'b1;
        line_bits(1'b1, 2);
        chk("midrst_no_valid", 32'(vcnt - v0), 32'h0);
        chk("midrst_no_ferr", 32'(fcnt - f0), 32'h0);
        chk("midrst_data_held0", 32'(o_data), 32'h0);
        send_frame(8'h12, 1'b1, 2);
        chk("post_rst_valid", 32'(vcnt - v0), 32'h1);
        chk("post_rst_data", 32'(o_data), 32'h12);

        chk("valid_ferr_overlap", 32'(both_cnt), 32'h0);
        chk("pulse_width", 32'(wide_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
